// File: rtl/avalon_bram_burst_pkg.sv
// Shared types and helpers for the Avalon-MM burst block-RAM agent.
//   state_t    : agent FSM states.
//   word_index : byte address -> word index, modulo the RAM depth.
package avalon_bram_burst_pkg;

    typedef enum logic [1:0] {
        RESET,
        IDLE,
        RD_BURST,
        WR_BURST
    } state_t;

    // Drops the byte-offset bits for a data_w-bit word, then keeps the low
    // ram_add_w bits so addresses beyond the RAM alias back into it.
    function automatic logic [31:0] word_index(input logic [63:0] address,
                                               input int          data_w,
                                               input int          ram_add_w);
        logic [63:0] word;
        word = address >> $clog2(data_w / 8);
        return 32'(word & ((64'd1 << ram_add_w) - 64'd1));
    endfunction

endpackage

// File: rtl/bram_byte_lanes.sv
// Single-port block RAM built from DATA_W/8 independent byte lanes.
//   clk   : clock
//   we    : write strobe, qualified per lane by be
//   be    : per-byte write enable
//   addr  : word address (depth 2**RAM_ADD_W)
//   wdata : write data
//   rdata : registered read data (old contents on a same-cycle write)
module bram_byte_lanes #(
    parameter int DATA_W    = 32,
    parameter int RAM_ADD_W = 11
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [RAM_ADD_W-1:0]  addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    localparam int LANES = DATA_W / 8;
    localparam int DEPTH = 2 ** RAM_ADD_W;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] q;

        always_ff @(posedge clk) begin
            if (we && be[i]) begin
                mem[addr] <= wdata[8*i +: 8];
            end
            q <= mem[addr];
        end

        assign rdata[8*i +: 8] = q;
    end

endmodule

// File: rtl/avalon_bram_burst.sv
// Avalon-MM block-RAM agent with linear bursts, byte enables and wrap.
//   clk, reset    : clock, asynchronous active-high reset
//   address       : byte address, mapped to a word index modulo depth
//   read, write   : commands (write also qualifies write-burst beats)
//   byteenable    : per-byte write enable
//   writedata     : write data
//   burstcount    : beats per command, 0 treated as 1
//   readdata      : read data, qualified by readdatavalid
//   readdatavalid : one pulse per read beat
//   waitrequest   : high during reset recovery and read bursts
module avalon_bram_burst
    import avalon_bram_burst_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int RAM_ADD_W    = 11,
    parameter int BURSTCOUNT_W = 4,
    parameter int ADDR_W       = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_W-1:0]       address,
    input  logic                    read,
    input  logic                    write,
    input  logic [DATA_W/8-1:0]     byteenable,
    input  logic [DATA_W-1:0]       writedata,
    input  logic [BURSTCOUNT_W-1:0] burstcount,
    output logic [DATA_W-1:0]       readdata,
    output logic                    readdatavalid,
    output logic                    waitrequest
);

    state_t                  state_q, state_d;
    logic [RAM_ADD_W-1:0]    idx_q, idx_d;
    logic [BURSTCOUNT_W-1:0] cnt_q, cnt_d;
    logic [BURSTCOUNT_W-1:0] last_q, last_d;
    logic [RAM_ADD_W-1:0]    cmd_idx;
    logic [BURSTCOUNT_W-1:0] cmd_last;
    logic                    rvld_d;
    logic                    ram_we;
    logic [RAM_ADD_W-1:0]    ram_addr;
    logic [DATA_W-1:0]       ram_rdata_p0;

    assign cmd_idx     = RAM_ADD_W'(word_index(64'(address), DATA_W, RAM_ADD_W));
    // Store the index of the final beat rather than the beat count.
    assign cmd_last    = (burstcount == '0) ? '0 : burstcount - 1'b1;
    assign waitrequest = (state_q == RESET) || (state_q == RD_BURST);

    bram_byte_lanes #(
        .DATA_W    (DATA_W),
        .RAM_ADD_W (RAM_ADD_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .be    (byteenable),
        .addr  (ram_addr),
        .wdata (writedata),
        .rdata (ram_rdata_p0)
    );

    // In IDLE the RAM is addressed straight from the bus, so beat 0 is
    // already in the RAM output register at the accept edge. In RD_BURST
    // the RAM fetches one word ahead of the beat being presented.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        rvld_d   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = cmd_idx;
        case (state_q)
            RESET: begin
                state_d = IDLE;
            end
            IDLE: begin
                if (read) begin
                    idx_d   = cmd_idx;
                    last_d  = cmd_last;
                    cnt_d   = '0;
                    state_d = RD_BURST;
                end else if (write) begin
                    ram_we = 1'b1;
                    idx_d  = cmd_idx;
                    last_d = cmd_last;
                    cnt_d  = BURSTCOUNT_W'(1);
                    if (cmd_last != '0) begin
                        state_d = WR_BURST;
                    end
                end
            end
            RD_BURST: begin
                ram_addr = idx_q + RAM_ADD_W'(cnt_q) + RAM_ADD_W'(1);
                rvld_d   = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == last_q) begin
                    state_d = IDLE;
                end
            end
            WR_BURST: begin
                ram_addr = idx_q + RAM_ADD_W'(cnt_q);
                if (write) begin
                    ram_we = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == last_q) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = RESET;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RESET;
            cnt_q   <= '0;
            last_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
        end
    end

    // Output stage: register the RAM word as the bus beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdatavalid <= 1'b0;
            readdata      <= '0;
        end else begin
            readdatavalid <= rvld_d;
            if (rvld_d) begin
                readdata <= ram_rdata_p0;
            end
        end
    end

endmodule
